// File: rtl/cm162a_result_fifo.sv
// Result FIFO for the cm162a stage: 5-bit words, valid/ready on both sides,
// plus a saturating counter of accepted words that differ from the previous one.
module cm162a_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [4:0]               in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [4:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         chg_cnt,
  input  logic                     chg_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    FULL    = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pointer wrap relies on DEPTH being a power of two.
  if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
    $error("cm162a_result_fifo: DEPTH must be 2, 4 or 8");
  end

  logic [4:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic [4:0]     last_word;
  logic           push;
  logic           pop;

  // Handshake outputs come only from registered state, never from in_valid/out_ready.
  assign in_ready  = (level_q < FULL);
  assign out_valid = (level_q != '0);
  assign out_data  = mem[rd_ptr];
  assign level     = level_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Change counter compares against the word held before this push; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_word <= 5'b00000;
      chg_cnt   <= '0;
    end else begin
      if (push) begin
        last_word <= in_data;
      end
      if (chg_clr) begin
        chg_cnt <= '0;
      end else if (push && (in_data != last_word) && (chg_cnt != CNT_MAX)) begin
        chg_cnt <= chg_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cm162a_result_fifo.sv
// Self-checking bench for cm162a_result_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cm162a_result_fifo;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic [7:0] chg_cnt;
  logic       chg_clr;

  cm162a_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .chg_cnt   (chg_cnt),
    .chg_clr   (chg_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents as a queue, change count and last accepted word.
  logic [4:0] mq[$];
  int         m_chg;
  logic [4:0] m_last;

  typedef struct {
    logic       iv;
    logic [4:0] d;
    logic       rdy;
    logic       clr;
    int         lvl;
    logic       ov;
    logic [4:0] od;
    int         chg;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_chg  = 0;
    m_last = 5'h00;
  endtask

  // Apply one clock edge with the currently driven inputs and advance the model.
  task automatic tick();
    bit do_push;
    bit do_pop;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() > 0);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (in_data != m_last && m_chg < CNT_MAX) m_chg++;
      m_last = in_data;
      mq.push_back(in_data);
    end
    if (chg_clr) m_chg = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_level"},     32'(level),     32'(mq.size()));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() < DEPTH));
    chk({tag, "_chg_cnt"},   32'(chg_cnt),   32'(m_chg));
    if (mq.size() != 0) chk({tag, "_out_data"}, 32'(out_data), 32'(mq[0]));
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = 5'h00;
    out_ready = 1'b0;
    chg_clr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic push_word(input logic [4:0] w, input logic rdy);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = rdy;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    model_clear();

    // Reset state
    do_reset();
    chk("reset_level", 32'(level), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_chg_cnt", 32'(chg_cnt), 0);

    // Single push, 1-cycle latency
    push_word(5'h15, 1'b0);
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_data", 32'(out_data), 32'h15);
    chk("single_level", 32'(level), 1);
    chk("single_chg_cnt", 32'(chg_cnt), 1);
    check_model("single");

    // Vector table: change counter behaviour with continuous draining
    tbl[0] = '{1'b1, 5'h00, 1'b1, 1'b0, 1, 1'b1, 5'h00, 0};
    tbl[1] = '{1'b1, 5'h00, 1'b1, 1'b0, 1, 1'b1, 5'h00, 0};
    tbl[2] = '{1'b1, 5'h00, 1'b1, 1'b0, 1, 1'b1, 5'h00, 0};
    tbl[3] = '{1'b1, 5'h1F, 1'b1, 1'b0, 1, 1'b1, 5'h1F, 1};
    tbl[4] = '{1'b1, 5'h1F, 1'b1, 1'b0, 1, 1'b1, 5'h1F, 1};
    tbl[5] = '{1'b1, 5'h00, 1'b1, 1'b0, 1, 1'b1, 5'h00, 2};
    tbl[6] = '{1'b1, 5'h1F, 1'b1, 1'b1, 1, 1'b1, 5'h1F, 0};
    tbl[7] = '{1'b0, 5'h00, 1'b1, 1'b0, 0, 1'b0, 5'h00, 0};
    tbl[8] = '{1'b1, 5'h1F, 1'b1, 1'b0, 1, 1'b1, 5'h1F, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].rdy;
      chg_clr   = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_chg_cnt", i), 32'(chg_cnt), 32'(tbl[i].chg));
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
    end
    idle_inputs();

    // Fill to full, hold a fifth word while stalled, then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(5'(i), 1'b0);
    chk("full_level", 32'(level), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 5'h05;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_level", i), 32'(level), 4);
    end
    chk("stall_head", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    tick();
    chk("pop1_level", 32'(level), 3);
    out_ready = 1'b0;
    tick();
    chk("refill_level", 32'(level), 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(i));
      tick();
    end
    chk("drain_level", 32'(level), 0);
    chk("drain_out_valid", 32'(out_valid), 0);
    idle_inputs();

    // Steady push+pop at level 2 across pointer wrap
    do_reset();
    push_word(5'h00, 1'b0);
    push_word(5'h01, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 5'(i + 2);
      chk($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
      tick();
      chk($sformatf("stream%0d_level", i), 32'(level), 2);
    end
    idle_inputs();

    // Saturation of the change counter
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = (i % 2 == 0) ? 5'h0A : 5'h15;
      tick();
      if (i % 50 == 49) check_model($sformatf("sat%0d", i));
    end
    chk("sat_chg_cnt", 32'(chg_cnt), 255);
    idle_inputs();

    // Asynchronous reset between edges with data stored
    do_reset();
    push_word(5'h03, 1'b0);
    push_word(5'h07, 1'b0);
    push_word(5'h0E, 1'b0);
    chk("pre_rst_level", 32'(level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("async_rst_level", 32'(level), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_chg_cnt", 32'(chg_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    push_word(5'h09, 1'b0);
    check_model("post_rst_push");

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? m_last : 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 2) != 0);
      chg_clr   = ($urandom_range(0, 15) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cm162a_result_fifo.md
CM162A_RESULT_FIFO -- requirements
Module: cm162a_result_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; legal values 2, 4, 8 only.
REQ-002 Parameter CNT_W, default 8, width of change counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream result word valid.
REQ-006 in_data  input  5  result word {s,r,q,p,o} from the cm162a stage.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_data  output  5  head entry value.
REQ-010 out_ready  input  1  downstream accepts head this cycle.
REQ-011 level  output  log2(DEPTH)+1  number of stored entries.
REQ-012 chg_cnt  output  CNT_W  count of accepted words differing from previous accepted word.
REQ-013 chg_clr  input  1  synchronous clear of chg_cnt.

Function
REQ-014 Push occurs on a clock edge when in_valid=1 and in_ready=1; pop when out_valid=1 and out_ready=1.
REQ-015 in_ready = (level < DEPTH), combinational from registered state only; no dependence on out_ready (no push-through when full).
REQ-016 out_valid = (level != 0); out_data = stored head entry; no bypass from in_data when empty.
REQ-017 Latency: word pushed at edge N appears on out_data with out_valid=1 after edge N when FIFO was empty (1 cycle).
REQ-018 Order strictly preserved; read and write pointers log2(DEPTH) bits, wrap modulo DEPTH.
REQ-019 Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
REQ-020 Push when full impossible (in_ready=0); in_valid held high while full stalls, data not lost or duplicated.
REQ-021 Pop when empty impossible (out_valid=0); out_ready ignored, out_data value don't-care but stable.
REQ-022 level increments on push-only, decrements on pop-only, holds otherwise; never exceeds DEPTH, never underflows.
REQ-023 Last-word register holds most recent pushed in_data; updated only on push.
REQ-024 On push, chg_cnt increments by 1 if in_data != last-word register value (pre-update); saturates at 2^CNT_W-1.
REQ-025 chg_clr=1 sets chg_cnt to 0 at next edge, overriding a same-cycle increment; last-word register unaffected.
REQ-026 out_data, in_ready, out_valid, level glitch-free relative to in_valid changes (registered-state derived).

Reset
REQ-027 rst_n=0 asynchronously forces: pointers 0, level 0, out_valid 0, in_ready 1 (after release), chg_cnt 0, last-word 5'b00000, storage contents don't-care.
REQ-028 Reset asserted mid-transfer discards all stored entries; no push or pop is recorded at the edge coincident with reset.
REQ-029 First edge after rst_n deassertion is a normal operating edge.

Verification
REQ-030 Reset, push 5'h15 once, out_ready=0 -> next cycle out_valid=1, out_data=5'h15, level=1, chg_cnt=1.
REQ-031 Push 5'h01,02,03,04 with out_ready=0 (DEPTH=4) -> level=4, in_ready=0; 5th word 5'h05 held on in_valid not accepted until one pop; pops return 01,02,03,04,05 in order.
REQ-032 Level=2, in_valid=1 and out_ready=1 for 10 cycles -> level stays 2, output order matches input order, pointers wrap without corruption.
REQ-033 Push 5'h00 three times after reset -> chg_cnt=0; then push 5'h1F, 5'h1F, 5'h00 -> chg_cnt=2; chg_clr with same-cycle differing push -> chg_cnt=0.
REQ-034 Push 300 alternating words 5'h0A/5'h15 with CNT_W=8 -> chg_cnt saturates at 255.
REQ-035 Fill to level=3, assert rst_n=0 between edges -> immediately level=0, out_valid=0, chg_cnt=0; after release in_ready=1.
